credit_splitter: RTL and testbench

Sequential decomposer at the output end of the credit path. It accepts a 4-bit accumulated credit total (0–8), which is the one-hot state sum encoded to binary by the next-state logic. It then splits that total back into a stream of 2-bit units (1–3) over a valid/ready handshake until the total is exhausted. Where the accumulator folds 2-bit inputs into a total, this block unfolds a total into 2-bit outputs. It sits between the credit accumulator and the dispense/return driver.

---
 rtl/credit_splitter.sv | 127 ++++++++++++
 tb/tb_credit_splitter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/credit_splitter.sv
// credit_splitter
//
// Takes an accumulated credit total (0..MAX_VALUE) and splits it into a
// stream of units of 1..MAX_UNIT. The largest unit goes first, and the
// stream stops when the total is used up. It sits between the credit
// accumulator and the dispense/return driver.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset; drops any partial split
//   load_valid  a total is presented on load_value
//   load_value  credit total to split (4 bits)
//   load_ready  a total can be accepted (IDLE only)
//   out_valid   out_unit carries a unit
//   out_unit    unit value 1..MAX_UNIT; 0 when out_valid=0
//   out_ready   downstream accepts the unit
//   remaining   credit still to emit
//   busy        high in EMIT or DONE
//   done        one-cycle pulse after the last unit, or after a zero load
//   err         one-cycle pulse when an oversize load is rejected
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once out_valid is asserted it stays high, and out_unit stays
// stable, until that transfer happens. Only reset can end it early.
// load_ready does not depend on load_valid.

module credit_splitter #(
  parameter int MAX_VALUE = 8,
  parameter int MAX_UNIT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [3:0] load_value,
  output logic       load_ready,
  output logic       out_valid,
  output logic [1:0] out_unit,
  input  logic       out_ready,
  output logic [3:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] MAX_VALUE_L = 4'(MAX_VALUE);
  localparam logic [3:0] MAX_UNIT_L  = 4'(MAX_UNIT);

  state_t     state_q, state_d;
  logic [3:0] remaining_q, remaining_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  // Greedy unit: the whole remainder if it fits, otherwise the largest unit.
  // Because it never exceeds remaining_q, the subtraction cannot underflow.
  logic [3:0] unit_full;
  assign unit_full = (remaining_q > MAX_UNIT_L) ? MAX_UNIT_L : remaining_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          if (load_value > MAX_VALUE_L) begin
            // Reject the load: state and remaining do not change.
            err_d = 1'b1;
          end else begin
            remaining_d = load_value;
            if (load_value == 4'd0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_EMIT;
            end
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          remaining_d = remaining_q - unit_full;
          if (remaining_d == 4'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= 4'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_EMIT);
  assign out_unit   = out_valid ? unit_full[1:0] : 2'd0;
  assign remaining  = remaining_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_credit_splitter.sv
// Bench for credit_splitter. Two instances share the same stimulus: one
// uses the default parameters and the other uses MAX_UNIT=1. Each instance
// is compared against a scoreboard. When a load is accepted, the scoreboard
// expands it into a greedy list of units. The outputs are derived from that
// list plus done/err pulse flags.

module tb_credit_splitter;

  localparam int MAX_VALUE = 8;
  localparam int MU0 = 3;
  localparam int MU1 = 1;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [3:0] load_value;
  logic       out_ready;

  logic       load_ready [2];
  logic       out_valid  [2];
  logic [1:0] out_unit   [2];
  logic [3:0] remaining  [2];
  logic       busy       [2];
  logic       done       [2];
  logic       err        [2];

  credit_splitter #(.MAX_VALUE(MAX_VALUE), .MAX_UNIT(MU0)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready[0]), .out_valid(out_valid[0]), .out_unit(out_unit[0]),
    .out_ready(out_ready), .remaining(remaining[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0])
  );

  credit_splitter #(.MAX_VALUE(MAX_VALUE), .MAX_UNIT(MU1)) dut_u1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready[1]), .out_valid(out_valid[1]), .out_unit(out_unit[1]),
    .out_ready(out_ready), .remaining(remaining[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q [2][$];
  bit         exp_done [2];
  bit         exp_err  [2];
  int         loaded_sum [2];
  int         emitted_sum [2];
  int         beats [2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unit_of(input int i);
    return (i == 0) ? MU0 : MU1;
  endfunction

  function automatic int queue_sum(input int i);
    int s = 0;
    foreach (exp_q[i][k]) s += int'(exp_q[i][k]);
    return s;
  endfunction

  // Advance the model of instance i across one clock edge, using the inputs
  // that were applied during the cycle before that edge.
  task automatic model_step(input int i, input bit r, input bit lv,
                            input int lval, input bit ordy);
    bit idle;
    bit nd;
    bit ne;
    int v;
    int u;
    if (r) begin
      exp_q[i].delete();
      exp_done[i] = 0;
      exp_err[i]  = 0;
      loaded_sum[i] = 0;
      emitted_sum[i] = 0;
      return;
    end
    idle = (exp_q[i].size() == 0) && !exp_done[i];
    nd = 0;
    ne = 0;
    if (exp_q[i].size() != 0) begin
      if (ordy) begin
        emitted_sum[i] += int'(exp_q[i][0]);
        beats[i]++;
        void'(exp_q[i].pop_front());
        if (exp_q[i].size() == 0) nd = 1;
      end
    end else if (idle && lv) begin
      if (lval > MAX_VALUE) begin
        ne = 1;
      end else if (lval == 0) begin
        nd = 1;
      end else begin
        loaded_sum[i] += lval;
        v = lval;
        while (v > 0) begin
          u = (v > unit_of(i)) ? unit_of(i) : v;
          exp_q[i].push_back(2'(u));
          v -= u;
        end
      end
    end
    exp_done[i] = nd;
    exp_err[i]  = ne;
  endtask

  task automatic check_outputs(input int i);
    bit emit;
    string p;
    emit = (exp_q[i].size() != 0);
    p = (i == 0) ? "u3" : "u1";
    check({p, ".load_ready"}, int'(load_ready[i]), int'(!emit && !exp_done[i]));
    check({p, ".out_valid"},  int'(out_valid[i]),  int'(emit));
    check({p, ".out_unit"},   int'(out_unit[i]),   emit ? int'(exp_q[i][0]) : 0);
    check({p, ".remaining"},  int'(remaining[i]),  queue_sum(i));
    check({p, ".busy"},       int'(busy[i]),       int'(emit || exp_done[i]));
    check({p, ".done"},       int'(done[i]),       int'(exp_done[i]));
    check({p, ".err"},        int'(err[i]),        int'(exp_err[i]));
    // Conservation: every unit emitted so far is part of a load, and the
    // emitted units plus the outstanding units add up to the loads exactly.
    check({p, ".sum"}, emitted_sum[i] + queue_sum(i), loaded_sum[i]);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit r, input bit lv, input int lval, input bit ordy);
    rst        = r;
    load_valid = lv;
    load_value = 4'(lval);
    out_ready  = ordy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r, lv, lval, ordy);
      check_outputs(i);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    load_value = 4'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_done[i] = 0; exp_err[i] = 0;
      loaded_sum[i] = 0; emitted_sum[i] = 0; beats[i] = 0;
    end

    // Reset, then check the values right after the reset edge.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);

    // Load 8 with out_ready held high. The default instance should emit 3,3,2.
    beats[0] = 0;
    cycle(0, 1, 8, 1);
    idle_cycles(4);
    check("u3.beats_load8", beats[0], 3);
    idle_cycles(6);

    // Load 7 with out_ready toggling; the held unit must stay stable.
    cycle(0, 1, 7, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    idle_cycles(8);

    // A zero load gives done with no out_valid.
    cycle(0, 1, 0, 1);
    idle_cycles(2);

    // An oversize load is rejected, then a load of 4 follows at once.
    cycle(0, 1, 9, 1);
    cycle(0, 1, 4, 1);
    idle_cycles(6);
    cycle(0, 1, 15, 0);
    idle_cycles(1);

    // Load 8, then assert reset after the first unit is accepted.
    cycle(0, 1, 8, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 1, 3, 1);
    idle_cycles(2);

    // Load 5 while the MAX_UNIT=1 instance is idle: it should take five beats.
    beats[1] = 0;
    cycle(0, 1, 5, 1);
    idle_cycles(6);
    check("u1.beats_load5", beats[1], 5);
    idle_cycles(2);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 2) != 0),
            $urandom_range(0, 15),
            ($urandom_range(0, 3) != 0));
    end
    idle_cycles(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
